// File: rtl/join_sync_param.sv
// join_sync_param
//   Clocked N-to-1 four-phase join. Collects requests from the channels
//   enabled in en_mask, raises one merged request downstream, returns the
//   downstream acknowledge to every participating channel and counts
//   completed transactions. Protocol violations set a sticky error flag.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en_mask    channels taking part in the next transaction
//   req_in     per-channel four-phase request (already synchronised)
//   ack_in     per-channel four-phase acknowledge
//   req_out    merged request to downstream
//   ack_out    downstream acknowledge (already synchronised)
//   busy       high whenever the FSM is not idle
//   err        sticky protocol-violation flag
//   txn_count  completed-transaction counter, wraps modulo 2^CNT_W
module join_sync_param #(
  parameter int unsigned size  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [size-1:0]  en_mask,
  input  logic [size-1:0]  req_in,
  output logic [size-1:0]  ack_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] txn_count
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REQ,
    ACK,
    RTZ
  } state_t;

  state_t            state_q, state_d;
  logic [size-1:0]   seen_q, seen_d;
  logic [size-1:0]   mask_q, mask_d;
  logic [size-1:0]   ack_in_q, ack_in_d;
  logic              req_out_q, req_out_d;
  logic              err_q, err_d;
  logic              ack_out_prev_q, ack_out_prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [size-1:0]   seen_next;
  logic [size-1:0]   start_hit;
  logic              all_in;
  logic              ack_rise;
  logic              withdrawn;

  always_comb begin
    state_d        = state_q;
    seen_d         = seen_q;
    mask_d         = mask_q;
    ack_in_d       = ack_in_q;
    req_out_d      = req_out_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    ack_out_prev_d = ack_out;

    seen_next = seen_q | (req_in & mask_q);
    all_in    = &(seen_next | ~mask_q);
    start_hit = req_in & en_mask;
    // Rising edge of ack_out, judged against last cycle's sample.
    ack_rise  = ack_out & ~ack_out_prev_q;
    // A masked request that was seen high has dropped before acknowledge.
    withdrawn = |(seen_q & mask_q & ~req_in);

    unique case (state_q)
      IDLE: begin
        if (ack_rise) err_d = 1'b1;
        // en_mask == 0 yields no start_hit, so requests are ignored.
        if (|start_hit) begin
          mask_d = en_mask;
          seen_d = start_hit;
          if (&(req_in | ~en_mask)) begin
            state_d   = REQ;
            req_out_d = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (ack_rise || withdrawn) err_d = 1'b1;
        seen_d = seen_next;
        if (all_in) begin
          state_d   = REQ;
          req_out_d = 1'b1;
        end
      end
      REQ: begin
        if (withdrawn) err_d = 1'b1;
        seen_d = seen_next;
        if (ack_out) begin
          state_d  = ACK;
          ack_in_d = mask_q;
        end
      end
      ACK: begin
        if ((req_in & mask_q) == '0) begin
          state_d   = RTZ;
          req_out_d = 1'b0;
        end
      end
      RTZ: begin
        if (!ack_out) begin
          state_d  = IDLE;
          ack_in_d = '0;
          seen_d   = '0;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      seen_q         <= '0;
      mask_q         <= '0;
      ack_in_q       <= '0;
      req_out_q      <= 1'b0;
      err_q          <= 1'b0;
      ack_out_prev_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      seen_q         <= seen_d;
      mask_q         <= mask_d;
      ack_in_q       <= ack_in_d;
      req_out_q      <= req_out_d;
      err_q          <= err_d;
      ack_out_prev_q <= ack_out_prev_d;
      cnt_q          <= cnt_d;
    end
  end

  assign ack_in    = ack_in_q;
  assign req_out   = req_out_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_join_sync_param.sv
module tb_join_sync_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // size=2, CNT_W=2 instance
  logic [1:0] en2 = '0, req2 = '0, ack_in2;
  logic       ack2 = 1'b0, req_out2, busy2, err2;
  logic [1:0] cnt2;

  // size=4, CNT_W=8 instance
  logic [3:0] en4 = '0, req4 = '0, ack_in4;
  logic       ack4 = 1'b0, req_out4, busy4, err4;
  logic [7:0] cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  join_sync_param #(.size(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .en_mask(en2), .req_in(req2), .ack_in(ack_in2),
    .req_out(req_out2), .ack_out(ack2), .busy(busy2), .err(err2), .txn_count(cnt2)
  );

  join_sync_param #(.size(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .en_mask(en4), .req_in(req4), .ack_in(ack_in4),
    .req_out(req_out4), .ack_out(ack4), .busy(busy4), .err(err4), .txn_count(cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full simultaneous transaction on the size=2 instance.
  task automatic txn2(input logic [1:0] exp_cnt);
    en2 = 2'b11; req2 = 2'b11;
    tick();
    chk("t2_req_out_hi", {31'd0, req_out2}, 32'd1);
    ack2 = 1'b1;
    tick();
    chk("t2_ack_in", {30'd0, ack_in2}, 32'd3);
    req2 = 2'b00;
    tick();
    chk("t2_req_out_lo", {31'd0, req_out2}, 32'd0);
    ack2 = 1'b0;
    tick();
    chk("t2_cnt", {30'd0, cnt2}, {30'd0, exp_cnt});
    chk("t2_busy", {31'd0, busy2}, 32'd0);
    chk("t2_ack_in_lo", {30'd0, ack_in2}, 32'd0);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_req_out2", {31'd0, req_out2}, 32'd0);
    chk("rst_ack_in2", {30'd0, ack_in2}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_err2", {31'd0, err2}, 32'd0);
    chk("rst_cnt2", {30'd0, cnt2}, 32'd0);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_cnt4", {24'd0, cnt4}, 32'd0);

    // Staggered arrivals on cycles 0,3,5,9: req_out only after the edge of cycle 9.
    en4 = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) req4 = 4'b0001;
      if (c == 3) req4 = 4'b0011;
      if (c == 5) req4 = 4'b0111;
      if (c == 9) req4 = 4'b1111;
      tick();
      chk($sformatf("stag_req_out_c%0d", c), {31'd0, req_out4}, (c == 9) ? 32'd1 : 32'd0);
    end
    chk("stag_busy", {31'd0, busy4}, 32'd1);
    ack4 = 1'b1;
    tick();
    chk("stag_ack_in", {28'd0, ack_in4}, 32'hf);
    req4 = 4'b0000;
    tick();
    ack4 = 1'b0;
    tick();
    chk("stag_cnt", {24'd0, cnt4}, 32'd1);
    chk("stag_err", {31'd0, err4}, 32'd0);

    // Partial mask 0101; unmasked channels never acknowledged, mask change ignored.
    en4 = 4'b0101; req4 = 4'b1111;
    tick();
    chk("mask_req_out", {31'd0, req_out4}, 32'd1);
    chk("mask_ack_in_pre", {28'd0, ack_in4}, 32'd0);
    en4 = 4'b1111;
    ack4 = 1'b1;
    tick();
    chk("mask_ack_in", {28'd0, ack_in4}, 32'h5);
    req4 = 4'b1010;
    tick();
    chk("mask_req_out_lo", {31'd0, req_out4}, 32'd0);
    chk("mask_ack_in_hold", {28'd0, ack_in4}, 32'h5);
    ack4 = 1'b0;
    tick();
    req4 = 4'b0000; en4 = 4'b0000;
    chk("mask_ack_in_lo", {28'd0, ack_in4}, 32'd0);
    chk("mask_cnt", {24'd0, cnt4}, 32'd2);
    chk("mask_err", {31'd0, err4}, 32'd0);
    chk("mask_busy", {31'd0, busy4}, 32'd0);

    // en_mask == 0 ignores requests.
    en2 = 2'b00; req2 = 2'b11;
    tick(); tick();
    chk("nomask_busy", {31'd0, busy2}, 32'd0);
    chk("nomask_req_out", {31'd0, req_out2}, 32'd0);
    req2 = 2'b00;

    txn2(2'd1);

    // Channel 0 withdraws before channel 1 arrives.
    en2 = 2'b11; req2 = 2'b01;
    tick();
    chk("wd_busy", {31'd0, busy2}, 32'd1);
    chk("wd_req_out_lo", {31'd0, req_out2}, 32'd0);
    req2 = 2'b00;
    tick();
    chk("wd_err", {31'd0, err2}, 32'd1);
    req2 = 2'b10;
    tick();
    chk("wd_req_out", {31'd0, req_out2}, 32'd1);
    ack2 = 1'b1;
    tick();
    req2 = 2'b00;
    tick();
    ack2 = 1'b0;
    tick();
    chk("wd_cnt", {30'd0, cnt2}, 32'd2);
    chk("wd_err_sticky", {31'd0, err2}, 32'd1);

    // Reset in ACK: outputs clear before the next clock edge.
    req2 = 2'b11;
    tick();
    ack2 = 1'b1;
    tick();
    chk("ar_ack_in_pre", {30'd0, ack_in2}, 32'd3);
    chk("ar_req_out_pre", {31'd0, req_out2}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_req_out", {31'd0, req_out2}, 32'd0);
    chk("ar_ack_in", {30'd0, ack_in2}, 32'd0);
    chk("ar_busy", {31'd0, busy2}, 32'd0);
    chk("ar_err", {31'd0, err2}, 32'd0);
    chk("ar_cnt", {30'd0, cnt2}, 32'd0);
    req2 = 2'b00; ack2 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("ar_idle", {31'd0, busy2}, 32'd0);

    // CNT_W=2 wrap: 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      txn2(2'((i + 1) % 4));
    end
    chk("wrap_err", {31'd0, err2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
